mips_main_control: RTL and testbench
====================================

Name: mips_main_control

Overview:
Multi-cycle main control FSM for the Mini-MIPS datapath. It sits directly upstream of alu_control: it decodes the 4-bit instruction opcode into a state sequence and drives the 3-bit ALUop consumed by alu_control, plus all datapath enables. Memory accesses use a ready handshake guarded by a timeout counter.

Parameters:
OPCODE_W, 4, opcode width; fixed, not for override.
MEM_TIMEOUT, 15, maximum cycles spent waiting for mem_ready in one memory state before a fault (legal range 1..255).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
opcode  input  4  instruction[15:12] from the instruction register
zero  input  1  ALU zero flag; feeds branch qualification only through pc_write_cond
mem_ready  input  1  memory completed the current access this cycle
ALUop  output  3  to alu_control: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 110 R-type (use func), 101/111 unused
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load qualified externally by zero
pc_src  output  2  00 ALU result, 01 ALUOut register, 10 jump target
ir_write  output  1  instruction register load
mem_read  output  1  memory read request
mem_write  output  1  memory write request
i_or_d  output  1  0 = PC address, 1 = ALUOut address
reg_write  output  1  register file write
reg_dst  output  1  1 = rd, 0 = rt
mem_to_reg  output  1  1 = MDR, 0 = ALUOut
alu_src_a  output  1  0 = PC, 1 = rs
alu_src_b  output  2  00 rt, 01 const 2, 10 sign-extended imm, 11 sign-extended imm<<1
illegal_op  output  1  one-cycle pulse on an undefined opcode
mem_fault  output  1  one-cycle pulse on a memory timeout
state_dbg  output  4  current state encoding

Behaviour:
- Opcodes: 0000 R-type, 0001 addi, 0010 andi, 0011 ori, 0100 slti, 0101 lw, 0110 sw, 0111 beq, 1000 j; 1001–1111 are illegal.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, R_WB 7, EXEC_I 8, I_WB 9, BRANCH 10, JUMP 11.
- Reset:
  - While reset = 1, every output is 0 and state_dbg = 0.
  - The next state is FETCH and the timeout counter clears.
  - Reset mid-instruction abandons the instruction; no write is issued after the reset edge.
- Output style: outputs decode combinationally from the registered state. Mealy terms appear only where stated below.
- Outputs not listed for a state are 0.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALUop=000, pc_src=00.
  - ir_write and pc_write equal mem_ready (Mealy).
  - On mem_ready the FSM goes to DECODE; otherwise it stays in FETCH.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, ALUop=000 (branch target into ALUOut).
  - Next state: R-type → EXEC_R; addi/andi/ori/slti → EXEC_I; lw/sw → MEM_ADDR; beq → BRANCH; j → JUMP.
  - Illegal opcode → FETCH, with illegal_op=1 for this cycle.
- EXEC_R: alu_src_a=1, alu_src_b=00, ALUop=110. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10. ALUop is 000 for addi, 010 for andi, 011 for ori, 100 for slti. Next state I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ALUop=000. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. On mem_ready → MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next state FETCH.
- MEM_WR: mem_write=1, i_or_d=1. On mem_ready → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, ALUop=001, pc_write_cond=1, pc_src=01. Next state FETCH.
- JUMP: pc_write=1, pc_src=10. Next state FETCH.
- Latency, counted from the FETCH cycle that sees mem_ready through the last state:
  - R-type and I-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and j: 3 cycles.
  - Each cycle spent waiting on memory adds 1.
- Timeout counter:
  - An 8-bit counter increments each cycle spent in FETCH, MEM_RD or MEM_WR without mem_ready.
  - It clears on mem_ready and on any state change.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0:
    - mem_fault pulses for 1 cycle.
    - The next state is FETCH; from FETCH itself, FETCH restarts with the counter at 0.
    - No reg_write or ir_write is issued.
  - mem_ready arriving in the same cycle the count reaches MEM_TIMEOUT counts as success; there is no fault.
- Every instruction returns to FETCH; there is no halt state.

Decomposition:
- mips_ctrl_pkg holds:
  - Opcode constants.
  - ALUop constants, which must match alu_control's decode.
  - State encodings.
  - alu_src_b and pc_src select constants.
- Sub-module mem_wait_timer: counter plus compare.
  - Inputs: clk, reset, waiting, mem_ready, clear.
  - Output: timeout.

Test Plan:
- R-type: reset 2 cycles, opcode=0000, mem_ready=1 → states 0,1,6,7,0. ALUop=110 in EXEC_R; reg_write=1, reg_dst=1 in R_WB.
- lw with 3-cycle memory latency in MEM_RD: opcode=0101 → states 0,1,2,3,3,3,4,0. mem_to_reg=1 and reg_write=1 only in MEM_WB.
- beq, opcode=0111 → BRANCH shows ALUop=001, pc_write_cond=1, pc_src=01. slti, opcode=0100 → EXEC_I shows ALUop=100.
- Illegal opcode=1010 → illegal_op high for exactly the DECODE cycle, next state FETCH, reg_write/mem_write never asserted.
- MEM_TIMEOUT=4, sw with mem_ready held 0 → mem_fault pulses once after 4 waiting cycles in MEM_WR, state returns to FETCH, mem_write deasserts.
- Reset asserted during MEM_WR → all outputs 0 in the reset cycle, state_dbg=0 afterwards, no further mem_write.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the Mini-MIPS main control: opcodes, ALUop codes, FSM states,
// datapath select codes and the per-state control bundle.
package mips_ctrl_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned ALUOP_W  = 3;
  localparam int unsigned CNT_W    = 8;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_LW    = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_SW    = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'b0111;
  localparam logic [OPCODE_W-1:0] OP_J     = 4'b1000;

  // Must stay aligned with alu_control's ALUop decode
  localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_SLT   = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_RTYPE = 3'b110;

  localparam logic [STATE_W-1:0] S_FETCH    = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE   = 4'd1;
  localparam logic [STATE_W-1:0] S_MEM_ADDR = 4'd2;
  localparam logic [STATE_W-1:0] S_MEM_RD   = 4'd3;
  localparam logic [STATE_W-1:0] S_MEM_WB   = 4'd4;
  localparam logic [STATE_W-1:0] S_MEM_WR   = 4'd5;
  localparam logic [STATE_W-1:0] S_EXEC_R   = 4'd6;
  localparam logic [STATE_W-1:0] S_R_WB     = 4'd7;
  localparam logic [STATE_W-1:0] S_EXEC_I   = 4'd8;
  localparam logic [STATE_W-1:0] S_I_WB     = 4'd9;
  localparam logic [STATE_W-1:0] S_BRANCH   = 4'd10;
  localparam logic [STATE_W-1:0] S_JUMP     = 4'd11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_CONST2  = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH1 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               pc_write;
    logic               pc_write_cond;
    logic [1:0]         pc_src;
    logic               ir_write;
    logic               mem_read;
    logic               mem_write;
    logic               i_or_d;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
  } ctrl_t;

  // ALU operation for the immediate-form arithmetic/logic instructions
  function automatic logic [ALUOP_W-1:0] itype_aluop(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_ANDI: itype_aluop = ALU_AND;
      OP_ORI:  itype_aluop = ALU_OR;
      OP_SLTI: itype_aluop = ALU_SLT;
      default: itype_aluop = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory and flags a timeout on the last allowed
// waiting cycle; a ready in that same cycle wins over the timeout.
module mem_wait_timer
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  input  logic clear,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  assign timeout = waiting && !mem_ready && (count == LIMIT);

  // Clearing on timeout lets a FETCH fault restart with the count at zero
  always_ff @(posedge clk) begin
    if (reset || clear || !waiting || mem_ready || timeout) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mips_main_control.sv
// Multi-cycle main control FSM for Mini-MIPS: sequences each instruction through its
// states and decodes datapath enables and ALUop from the current state.
module mips_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [ALUOP_W-1:0]  ALUop,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_src,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                illegal_op,
  output logic                mem_fault,
  output logic [STATE_W-1:0]  state_dbg
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  ctrl_t              ctrl;
  ctrl_t              ctrl_out;
  logic               illegal;
  logic               waiting;
  logic               timeout;
  logic               state_change;

  // Branch qualification by zero happens outside this block
  logic unused_zero;
  assign unused_zero = zero;

  assign waiting      = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign state_change = (state_next != state);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .waiting  (waiting),
    .mem_ready(mem_ready),
    .clear    (state_change),
    .timeout  (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    ctrl       = '0;
    state_next = state;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_CONST2;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH1;
        case (opcode)
          OP_RTYPE:                         state_next = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_EXEC_I;
          OP_LW, OP_SW:                     state_next = S_MEM_ADDR;
          OP_BEQ:                           state_next = S_BRANCH;
          OP_J:                             state_next = S_JUMP;
          default: begin
            state_next = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_RTYPE;
        state_next     = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_next     = S_FETCH;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = itype_aluop(opcode);
        state_next     = S_I_WB;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
        state_next     = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_next     = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (mem_ready)    state_next = S_MEM_WB;
        else if (timeout) state_next = S_FETCH;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_next      = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (mem_ready || timeout) state_next = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PCSRC_ALUOUT;
        state_next         = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
        state_next    = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Everything is forced low while reset is held
  assign ctrl_out   = reset ? '0 : ctrl;
  assign illegal_op = !reset && illegal;
  assign mem_fault  = !reset && timeout;
  assign state_dbg  = reset ? '0 : state;

  assign ALUop         = ctrl_out.alu_op;
  assign pc_write      = ctrl_out.pc_write;
  assign pc_write_cond = ctrl_out.pc_write_cond;
  assign pc_src        = ctrl_out.pc_src;
  assign ir_write      = ctrl_out.ir_write;
  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign i_or_d        = ctrl_out.i_or_d;
  assign reg_write     = ctrl_out.reg_write;
  assign reg_dst       = ctrl_out.reg_dst;
  assign mem_to_reg    = ctrl_out.mem_to_reg;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;

endmodule

// File: tb/tb_mips_main_control.sv
// Directed-vector bench for mips_main_control with a 4-cycle memory timeout.
module tb_mips_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [2:0] ALUop;
  logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op, mem_fault;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  mips_main_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALUop(ALUop), .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .illegal_op(illegal_op),
    .mem_fault(mem_fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [20:0] all_out;
  assign all_out = {ALUop, pc_write, pc_write_cond, pc_src, ir_write, mem_read, mem_write,
                    i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                    illegal_op, mem_fault, 2'b00};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle; outputs are then checked mid-cycle
  task automatic cyc(input logic rst, input logic [3:0] op, input logic rdy);
    @(negedge clk);
    reset     = rst;
    opcode    = op;
    mem_ready = rdy;
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b0;

    // reset holds all outputs low even with mem_ready high
    cyc(1'b1, 4'd0, 1'b1);
    chk("rst_outs", 32'(all_out), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    cyc(1'b1, 4'd0, 1'b1);
    chk("rst_outs2", 32'(all_out), 32'd0);

    // R-type: 0,1,6,7,0
    cyc(1'b0, 4'd0, 1'b1);
    chk("r_fetch_st", 32'(state_dbg), 32'd0);
    chk("r_fetch_ctl", 32'({mem_read, ir_write, pc_write, i_or_d, alu_src_a, alu_src_b, ALUop}),
        32'b1_1_1_0_0_01_000);
    cyc(1'b0, 4'd0, 1'b0);
    chk("r_dec_st", 32'(state_dbg), 32'd1);
    chk("r_dec_srcb", 32'({alu_src_a, alu_src_b, ALUop}), 32'b0_11_000);
    cyc(1'b0, 4'd0, 1'b0);
    chk("r_exec_st", 32'(state_dbg), 32'd6);
    chk("r_exec_ctl", 32'({ALUop, alu_src_a, alu_src_b}), 32'b110_1_00);
    cyc(1'b0, 4'd0, 1'b0);
    chk("r_wb_st", 32'(state_dbg), 32'd7);
    chk("r_wb_ctl", 32'({reg_write, reg_dst, mem_to_reg}), 32'b110);

    // lw with three cycles in MEM_RD: 0,1,2,3,3,3,4,0
    cyc(1'b0, 4'd5, 1'b1);
    chk("lw_fetch_st", 32'(state_dbg), 32'd0);
    cyc(1'b0, 4'd5, 1'b0);
    chk("lw_dec_st", 32'(state_dbg), 32'd1);
    cyc(1'b0, 4'd5, 1'b0);
    chk("lw_addr_st", 32'(state_dbg), 32'd2);
    chk("lw_addr_ctl", 32'({alu_src_a, alu_src_b, ALUop}), 32'b1_10_000);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'd5, (i == 2) ? 1'b1 : 1'b0);
      chk("lw_rd_st", 32'(state_dbg), 32'd3);
      chk("lw_rd_ctl", 32'({mem_read, i_or_d, reg_write, mem_to_reg, mem_fault}), 32'b11000);
    end
    cyc(1'b0, 4'd5, 1'b0);
    chk("lw_wb_st", 32'(state_dbg), 32'd4);
    chk("lw_wb_ctl", 32'({reg_write, reg_dst, mem_to_reg}), 32'b101);

    // beq: 0,1,10,0
    cyc(1'b0, 4'd7, 1'b1);
    chk("beq_fetch_st", 32'(state_dbg), 32'd0);
    cyc(1'b0, 4'd7, 1'b0);
    cyc(1'b0, 4'd7, 1'b0);
    chk("beq_st", 32'(state_dbg), 32'd10);
    chk("beq_ctl", 32'({ALUop, pc_write_cond, pc_src, pc_write, alu_src_a, alu_src_b}),
        32'b001_1_01_0_1_00);

    // slti: 0,1,8,9,0
    cyc(1'b0, 4'd4, 1'b1);
    chk("slti_fetch_st", 32'(state_dbg), 32'd0);
    cyc(1'b0, 4'd4, 1'b0);
    cyc(1'b0, 4'd4, 1'b0);
    chk("slti_exec_st", 32'(state_dbg), 32'd8);
    chk("slti_exec_ctl", 32'({ALUop, alu_src_a, alu_src_b}), 32'b100_1_10);
    cyc(1'b0, 4'd4, 1'b0);
    chk("slti_wb_st", 32'(state_dbg), 32'd9);
    chk("slti_wb_ctl", 32'({reg_write, reg_dst, mem_to_reg}), 32'b100);

    // ori picks ALUop 011
    cyc(1'b0, 4'd3, 1'b1);
    cyc(1'b0, 4'd3, 1'b0);
    cyc(1'b0, 4'd3, 1'b0);
    chk("ori_exec_aluop", 32'(ALUop), 32'd3);
    cyc(1'b0, 4'd3, 1'b0);

    // j: 0,1,11,0
    cyc(1'b0, 4'd8, 1'b1);
    cyc(1'b0, 4'd8, 1'b0);
    cyc(1'b0, 4'd8, 1'b0);
    chk("j_st", 32'(state_dbg), 32'd11);
    chk("j_ctl", 32'({pc_write, pc_src, pc_write_cond}), 32'b1_10_0);

    // illegal opcode: pulse only in DECODE, then FETCH
    cyc(1'b0, 4'd10, 1'b1);
    chk("ill_fetch_pulse", 32'(illegal_op), 32'd0);
    cyc(1'b0, 4'd10, 1'b0);
    chk("ill_dec_st", 32'(state_dbg), 32'd1);
    chk("ill_dec_ctl", 32'({illegal_op, reg_write, mem_write}), 32'b100);
    cyc(1'b0, 4'd10, 1'b0);
    chk("ill_next_st", 32'(state_dbg), 32'd0);
    chk("ill_next_ctl", 32'({illegal_op, reg_write, mem_write}), 32'b000);

    // sw with memory stalled: fault on the 4th MEM_WR cycle, back to FETCH
    cyc(1'b0, 4'd6, 1'b1);
    cyc(1'b0, 4'd6, 1'b0);
    cyc(1'b0, 4'd6, 1'b0);
    chk("sw_addr_st", 32'(state_dbg), 32'd2);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 4'd6, 1'b0);
      chk("sw_wr_st", 32'(state_dbg), 32'd5);
      chk("sw_wr_ctl", 32'({mem_write, i_or_d}), 32'b11);
      chk("sw_fault", 32'(mem_fault), (i == 3) ? 32'd1 : 32'd0);
    end
    cyc(1'b0, 4'd6, 1'b0);
    chk("sw_to_st", 32'(state_dbg), 32'd0);
    chk("sw_to_ctl", 32'({mem_write, mem_fault, ir_write}), 32'b000);

    // FETCH was entered by a state change, so the count is 0: fault on 4th FETCH wait
    for (int i = 1; i < 4; i++) begin
      cyc(1'b0, 4'd6, 1'b0);
      chk("fetch_to_fault", 32'(mem_fault), (i == 3) ? 32'd1 : 32'd0);
      chk("fetch_to_st", 32'(state_dbg), 32'd0);
    end
    // count restarted: next fault is four cycles later, not immediately
    cyc(1'b0, 4'd6, 1'b0);
    chk("fetch_restart_fault", 32'(mem_fault), 32'd0);
    cyc(1'b0, 4'd6, 1'b0);
    cyc(1'b0, 4'd6, 1'b0);
    cyc(1'b0, 4'd6, 1'b0);
    chk("fetch_refault", 32'({mem_fault, ir_write}), 32'b10);

    // ready on the limit cycle is a success
    cyc(1'b0, 4'd6, 1'b1);
    cyc(1'b0, 4'd6, 1'b0);
    cyc(1'b0, 4'd6, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 4'd6, (i == 3) ? 1'b1 : 1'b0);
      chk("sw_edge_fault", 32'(mem_fault), 32'd0);
    end
    cyc(1'b0, 4'd6, 1'b0);
    chk("sw_edge_st", 32'(state_dbg), 32'd0);

    // reset during MEM_WR abandons the store
    cyc(1'b0, 4'd6, 1'b1);
    cyc(1'b0, 4'd6, 1'b0);
    cyc(1'b0, 4'd6, 1'b0);
    cyc(1'b0, 4'd6, 1'b0);
    chk("rst_wr_pre", 32'(state_dbg), 32'd5);
    cyc(1'b1, 4'd6, 1'b1);
    chk("rst_wr_outs", 32'(all_out), 32'd0);
    chk("rst_wr_state", 32'(state_dbg), 32'd0);
    cyc(1'b0, 4'd6, 1'b0);
    chk("rst_wr_after_st", 32'(state_dbg), 32'd0);
    chk("rst_wr_after_mw", 32'({mem_write, reg_write}), 32'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
